// File: rtl/valu_issue_ctrl.sv
// Vector issue/writeback sequencer: accepts one OPIVV/OPIVX/OPIVI instruction,
// drives the VALU for its fixed latency, then writes the result back to the VRF.
module valu_issue_ctrl #(
  parameter int VLEN       = 256,
  parameter int ELEM_SIZE  = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_VREGS  = 32,
  parameter int VALU_LAT   = 2,
  localparam int AW        = $clog2(NUM_VREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [6:0]            instr_funct7,
  input  logic [2:0]            instr_funct3,
  input  logic [AW-1:0]         instr_vd,
  input  logic [AW-1:0]         instr_vs1,
  input  logic [AW-1:0]         instr_vs2,
  input  logic [DATA_WIDTH-1:0] instr_rs1,
  input  logic [4:0]            instr_simm5,
  output logic [AW-1:0]         vrf_raddr1,
  output logic [AW-1:0]         vrf_raddr2,
  input  logic [VLEN-1:0]       vrf_rdata1,
  input  logic [VLEN-1:0]       vrf_rdata2,
  output logic [VLEN-1:0]       valu_op1,
  output logic [VLEN-1:0]       valu_op2,
  output logic [ELEM_SIZE-1:0]  valu_imm,
  output logic                  valu_is_scalar,
  output logic [6:0]            valu_funct7,
  output logic [2:0]            valu_funct3,
  input  logic [VLEN-1:0]       valu_result,
  input  logic                  valu_valid,
  output logic                  vrf_we,
  output logic [AW-1:0]         vrf_waddr,
  output logic [VLEN-1:0]       vrf_wdata,
  output logic                  illegal,
  output logic                  wb_err,
  output logic                  busy
);

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0000100;
  localparam logic [6:0] F7_MUL = 7'b1001011;
  localparam logic [6:0] F7_DIV = 7'b1001100;
  localparam logic [6:0] F7_NOP = 7'h7F;
  localparam logic [2:0] F3_VV  = 3'b000;
  localparam logic [2:0] F3_VX  = 3'b100;
  localparam logic [2:0] F3_VI  = 3'b011;
  localparam int CW = (VALU_LAT > 1) ? $clog2(VALU_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB,
    ERR
  } state_t;

  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;

  logic [6:0]            lat_f7;
  logic [2:0]            lat_f3;
  logic [AW-1:0]         lat_vd;
  logic [AW-1:0]         lat_vs1;
  logic [AW-1:0]         lat_vs2;
  logic [DATA_WIDTH-1:0] lat_rs1;
  logic [4:0]            lat_simm5;

  logic accept;
  logic legal;
  logic [ELEM_SIZE-1:0] rs1_e;
  logic [ELEM_SIZE-1:0] imm_e;

  assign instr_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign accept      = instr_valid && instr_ready;

  assign legal = (instr_funct7 inside {F7_ADD, F7_SUB, F7_MUL, F7_DIV}) &&
                 (instr_funct3 inside {F3_VV, F3_VX, F3_VI});

  assign rs1_e = ELEM_SIZE'(lat_rs1);
  assign imm_e = {{(ELEM_SIZE-5){lat_simm5[4]}}, lat_simm5};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_f7    <= '0;
      lat_f3    <= '0;
      lat_vd    <= '0;
      lat_vs1   <= '0;
      lat_vs2   <= '0;
      lat_rs1   <= '0;
      lat_simm5 <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        lat_f7    <= instr_funct7;
        lat_f3    <= instr_funct3;
        lat_vd    <= instr_vd;
        lat_vs1   <= instr_vs1;
        lat_vs2   <= instr_vs2;
        lat_rs1   <= instr_rs1;
        lat_simm5 <= instr_simm5;
      end
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (legal) begin
            state_nx = EXEC;
            cnt_nx   = CW'(VALU_LAT - 1);
          end else begin
            state_nx = ERR;
          end
        end
      end
      EXEC: begin
        if (cnt == '0) state_nx = WB;
        else cnt_nx = cnt - CW'(1);
      end
      WB:      state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // VALU inputs are a pure function of the latched instruction while in
  // EXEC, so they stay stable for the whole latency window.
  always_comb begin
    vrf_raddr1     = '0;
    vrf_raddr2     = '0;
    valu_op1       = '0;
    valu_op2       = '0;
    valu_imm       = '0;
    valu_is_scalar = 1'b0;
    valu_funct7    = F7_NOP;
    valu_funct3    = '0;
    if (state == EXEC) begin
      vrf_raddr1  = lat_vs1;
      vrf_raddr2  = lat_vs2;
      valu_op1    = vrf_rdata1;
      valu_funct7 = lat_f7;
      valu_funct3 = lat_f3;
      unique case (1'b1)
        (lat_f3 == F3_VV): begin
          valu_op2 = vrf_rdata2;
        end
        (lat_f3 == F3_VX): begin
          valu_op2       = VLEN'(rs1_e);
          valu_is_scalar = 1'b1;
        end
        (lat_f3 == F3_VI): begin
          valu_op2       = VLEN'(imm_e);
          valu_imm       = imm_e;
          valu_is_scalar = 1'b1;
        end
        default: begin
          valu_op2 = '0;
        end
      endcase
    end
  end

  always_comb begin
    vrf_we    = (state == WB);
    vrf_waddr = (state == WB) ? lat_vd : '0;
    vrf_wdata = (state == WB) ? valu_result : '0;
    wb_err    = (state == WB) && !valu_valid;
    illegal   = (state == ERR);
  end

endmodule

// File: tb/tb_valu_issue_ctrl.sv
// Directed bench for valu_issue_ctrl with a behavioural VRF and a
// two-stage VALU stand-in.
module tb_valu_issue_ctrl;

  localparam int VLEN = 256;
  localparam int ES   = 32;
  localparam int DW   = 32;
  localparam int NV   = 32;
  localparam int AW   = 5;
  localparam int LAT  = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            instr_valid;
  logic            instr_ready;
  logic [6:0]      instr_funct7;
  logic [2:0]      instr_funct3;
  logic [AW-1:0]   instr_vd;
  logic [AW-1:0]   instr_vs1;
  logic [AW-1:0]   instr_vs2;
  logic [DW-1:0]   instr_rs1;
  logic [4:0]      instr_simm5;
  logic [AW-1:0]   vrf_raddr1;
  logic [AW-1:0]   vrf_raddr2;
  logic [VLEN-1:0] vrf_rdata1;
  logic [VLEN-1:0] vrf_rdata2;
  logic [VLEN-1:0] valu_op1;
  logic [VLEN-1:0] valu_op2;
  logic [ES-1:0]   valu_imm;
  logic            valu_is_scalar;
  logic [6:0]      valu_funct7;
  logic [2:0]      valu_funct3;
  logic [VLEN-1:0] valu_result;
  logic            valu_valid;
  logic            vrf_we;
  logic [AW-1:0]   vrf_waddr;
  logic [VLEN-1:0] vrf_wdata;
  logic            illegal;
  logic            wb_err;
  logic            busy;

  always #5 clk = ~clk;

  valu_issue_ctrl #(
    .VLEN(VLEN), .ELEM_SIZE(ES), .DATA_WIDTH(DW),
    .NUM_VREGS(NV), .VALU_LAT(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_funct7(instr_funct7), .instr_funct3(instr_funct3),
    .instr_vd(instr_vd), .instr_vs1(instr_vs1), .instr_vs2(instr_vs2),
    .instr_rs1(instr_rs1), .instr_simm5(instr_simm5),
    .vrf_raddr1(vrf_raddr1), .vrf_raddr2(vrf_raddr2),
    .vrf_rdata1(vrf_rdata1), .vrf_rdata2(vrf_rdata2),
    .valu_op1(valu_op1), .valu_op2(valu_op2), .valu_imm(valu_imm),
    .valu_is_scalar(valu_is_scalar), .valu_funct7(valu_funct7),
    .valu_funct3(valu_funct3), .valu_result(valu_result),
    .valu_valid(valu_valid), .vrf_we(vrf_we), .vrf_waddr(vrf_waddr),
    .vrf_wdata(vrf_wdata), .illegal(illegal), .wb_err(wb_err), .busy(busy)
  );

  logic [VLEN-1:0] vrf [NV];
  assign vrf_rdata1 = vrf[vrf_raddr1];
  assign vrf_rdata2 = vrf[vrf_raddr2];

  function automatic logic [VLEN-1:0] alu(input logic [6:0] f7,
                                          input logic [VLEN-1:0] a_v,
                                          input logic [VLEN-1:0] b_v,
                                          input logic sc);
    logic [VLEN-1:0] r;
    logic [ES-1:0] a, b;
    r = '0;
    for (int i = 0; i < VLEN/ES; i++) begin
      a = a_v[i*ES +: ES];
      b = sc ? b_v[ES-1:0] : b_v[i*ES +: ES];
      case (f7)
        7'h00:   r[i*ES +: ES] = a + b;
        7'h04:   r[i*ES +: ES] = a - b;
        7'h4B:   r[i*ES +: ES] = a * b;
        7'h4C:   r[i*ES +: ES] = (b == 0) ? '1 : a / b;
        default: r[i*ES +: ES] = '0;
      endcase
    end
    return r;
  endfunction

  logic [VLEN-1:0] s1_r, s2_r;
  logic            s1_v, s2_v;
  logic            force_inval;

  always_ff @(posedge clk) begin
    s1_r <= alu(valu_funct7, valu_op1, valu_op2, valu_is_scalar);
    s1_v <= (valu_funct7 != 7'h7F);
    s2_r <= s1_r;
    s2_v <= s1_v;
  end
  assign valu_result = s2_r;
  assign valu_valid  = s2_v && !force_inval;

  typedef struct {
    logic [6:0]      f7;
    logic [2:0]      f3;
    logic [AW-1:0]   vd;
    logic [AW-1:0]   vs1;
    logic [AW-1:0]   vs2;
    logic [DW-1:0]   rs1;
    logic [4:0]      simm5;
    logic            ill;
    logic            sc;
    logic [ES-1:0]   imm;
    logic [VLEN-1:0] wd;
  } vec_t;

  vec_t tbl [9];
  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [VLEN-1:0] got,
                     input logic [VLEN-1:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", nm, got, exp);
  endtask

  function automatic logic [VLEN-1:0] mkvec(input logic [ES-1:0] base,
                                            input logic [ES-1:0] step);
    logic [VLEN-1:0] r;
    for (int i = 0; i < VLEN/ES; i++) r[i*ES +: ES] = base + step * ES'(i);
    return r;
  endfunction

  task automatic drive(input vec_t v);
    instr_funct7 = v.f7;
    instr_funct3 = v.f3;
    instr_vd     = v.vd;
    instr_vs1    = v.vs1;
    instr_vs2    = v.vs2;
    instr_rs1    = v.rs1;
    instr_simm5  = v.simm5;
  endtask

  task automatic issue(input vec_t v, input logic exp_err, input string tag);
    int w;
    @(negedge clk);
    drive(v);
    instr_valid = 1'b1;
    w = 0;
    while (!instr_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!instr_ready) chk({tag, "_ready_timeout"}, 0, 1);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    if (v.ill) begin
      chk({tag, "_illegal"}, illegal, 1);
      chk({tag, "_ill_ready"}, instr_ready, 0);
      chk({tag, "_ill_f7"}, valu_funct7, 7'h7F);
      chk({tag, "_ill_we1"}, vrf_we, 0);
      @(posedge clk); #1;
      chk({tag, "_ill_ready2"}, instr_ready, 1);
      chk({tag, "_ill_clr"}, illegal, 0);
      chk({tag, "_ill_we2"}, vrf_we, 0);
    end else begin
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_f7"}, valu_funct7, v.f7);
      chk({tag, "_scalar"}, valu_is_scalar, v.sc);
      chk({tag, "_imm"}, valu_imm, v.imm);
      chk({tag, "_we_e1"}, vrf_we, 0);
      @(posedge clk); #1;
      chk({tag, "_f7_e2"}, valu_funct7, v.f7);
      chk({tag, "_we_e2"}, vrf_we, 0);
      @(posedge clk); #1;
      chk({tag, "_we"}, vrf_we, 1);
      chk({tag, "_waddr"}, vrf_waddr, v.vd);
      chk({tag, "_wdata"}, vrf_wdata, v.wd);
      chk({tag, "_wb_err"}, wb_err, exp_err);
      chk({tag, "_f7_wb"}, valu_funct7, 7'h7F);
      @(posedge clk); #1;
      chk({tag, "_ready_after"}, instr_ready, 1);
    end
  endtask

  initial begin
    logic [8:0] we_m, rdy_m;
    logic saw_we;
    rst_n = 1'b0;
    force_inval = 1'b0;
    instr_valid = 1'b0;
    drive('{7'h0, 3'h0, 5'd0, 5'd0, 5'd0, 32'h0, 5'h0, 1'b0, 1'b0, 32'h0, '0});
    for (int i = 0; i < NV; i++) vrf[i] = '0;
    vrf[1] = mkvec(32'd1, 32'd1);
    vrf[2] = mkvec(32'd10, 32'd0);
    vrf[3] = mkvec(32'd100, 32'd0);
    vrf[5] = mkvec(32'd7, 32'd0);

    tbl[0] = '{7'h00, 3'b000, 5'd4, 5'd1, 5'd2, 32'd0, 5'd0,
               1'b0, 1'b0, 32'd0, mkvec(32'd11, 32'd1)};
    tbl[1] = '{7'h04, 3'b100, 5'd6, 5'd3, 5'd9, 32'd5, 5'd0,
               1'b0, 1'b1, 32'd0, mkvec(32'd95, 32'd0)};
    tbl[2] = '{7'h00, 3'b011, 5'd7, 5'd0, 5'd0, 32'd0, 5'b11111,
               1'b0, 1'b1, 32'hFFFFFFFF, mkvec(32'hFFFFFFFF, 32'd0)};
    tbl[3] = '{7'h4C, 3'b000, 5'd8, 5'd5, 5'd0, 32'd0, 5'd0,
               1'b0, 1'b0, 32'd0, mkvec(32'hFFFFFFFF, 32'd0)};
    tbl[4] = '{7'h4C, 3'b011, 5'd9, 5'd5, 5'd0, 32'd0, 5'd0,
               1'b0, 1'b1, 32'd0, mkvec(32'hFFFFFFFF, 32'd0)};
    tbl[5] = '{7'h4B, 3'b000, 5'd10, 5'd1, 5'd2, 32'd0, 5'd0,
               1'b0, 1'b0, 32'd0, mkvec(32'd10, 32'd10)};
    tbl[6] = '{7'h00, 3'b100, 5'd11, 5'd1, 5'd0, 32'hFFFFFFFF, 5'd0,
               1'b0, 1'b1, 32'd0, mkvec(32'd0, 32'd1)};
    tbl[7] = '{7'h00, 3'b001, 5'd12, 5'd1, 5'd2, 32'd0, 5'd0,
               1'b1, 1'b0, 32'd0, '0};
    tbl[8] = '{7'h01, 3'b000, 5'd13, 5'd1, 5'd2, 32'd0, 5'd0,
               1'b1, 1'b0, 32'd0, '0};

    @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_we", vrf_we, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_f7", valu_funct7, 7'h7F);
    chk("rst_op1", valu_op1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", instr_ready, 1);
    chk("rst_wb_err", wb_err, 0);

    for (int i = 0; i < 9; i++) issue(tbl[i], 1'b0, $sformatf("v%0d", i));

    force_inval = 1'b1;
    issue(tbl[0], 1'b1, "wberr");
    force_inval = 1'b0;

    // Back-to-back issue with instr_valid held high.
    @(negedge clk);
    drive(tbl[0]);
    instr_valid = 1'b1;
    we_m = '0;
    rdy_m = '0;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      #1;
      we_m[k]  = vrf_we;
      rdy_m[k] = instr_ready;
      if (k == 5) instr_valid = 1'b0;
      @(posedge clk);
    end
    chk("b2b_we_cycles", we_m, 9'b0_1000_1000);
    chk("b2b_ready_cycles", rdy_m, 9'b1_0001_0000);

    // Reset pulse while in EXEC drops the instruction.
    @(negedge clk);
    drive(tbl[0]);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("rstx_busy_pre", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstx_busy", busy, 0);
    chk("rstx_f7", valu_funct7, 7'h7F);
    chk("rstx_we", vrf_we, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      saw_we = saw_we | vrf_we;
    end
    chk("rstx_no_we", saw_we, 0);
    chk("rstx_ready", instr_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
